// File: rtl/spi_program_loader.sv
// Buffers host {addr, instr} words and shifts them into the processor's receive buffer, then runs it.
// Optional run watchdog enabled by defining LOADER_TIMEOUT_EN.
module spi_program_loader #(
   parameter int FIFO_DEPTH     = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int MAX_RUN_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid_in,
   output logic       wr_ready_out,
   input  logic [3:0] wr_addr_in,
   input  logic [7:0] wr_data_in,
   input  logic       start_in,
   output logic       busy_out,
   output logic       run_done_out,
   output logic       timeout_out,
   output logic       csi_n_out,
   output logic       csd_n_out,
   output logic       mosi_out,
   output logic       proc_en_out,
   input  logic       proc_done_in
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_SHIFT    = 3'd2;
   localparam logic [2:0] S_GAP      = 3'd3;
   localparam logic [2:0] S_RUN_WAIT = 3'd4;
   localparam logic [2:0] S_RUN      = 3'd5;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (GAP_CYCLES < 2) begin : g_bad_gap
      $error("GAP_CYCLES must be at least 2");
   end
   if (MAX_RUN_CYCLES < 1) begin : g_bad_max_run
      $error("MAX_RUN_CYCLES must be at least 1");
   end

   logic [11:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [2:0]       state_q, state_d;
   logic [11:0]      sr_q, sr_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             start_pending_q, start_pending_d;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic run_hit;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign push  = wr_valid_in & ~full;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {wr_data_in, wr_addr_in};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      pop       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Loading always wins over running a pending start.
            if (!empty) begin
               pop     = 1'b1;
               sr_d    = fifo_mem[rd_ptr_q];
               state_d = S_SETUP;
            end else if (start_pending_q) begin
               state_d = S_RUN_WAIT;
            end
         end
         S_SETUP: begin
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
         end
         S_SHIFT: begin
            sr_d = {1'b0, sr_q[11:1]};
            if (bit_cnt_q == 4'd11) begin
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_ONE;
            end
         end
         S_RUN_WAIT: begin
            if (run_hit) begin
               state_d = S_IDLE;
            end else if (!proc_done_in) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (proc_done_in || run_hit) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_pending_d = start_pending_q;
      if (state_q == S_IDLE && empty && start_pending_q) begin
         start_pending_d = 1'b0;
      end
      if (start_in) begin
         start_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         state_q         <= S_IDLE;
         sr_q            <= '0;
         bit_cnt_q       <= '0;
         gap_cnt_q       <= '0;
         start_pending_q <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         state_q         <= state_d;
         sr_q            <= sr_d;
         bit_cnt_q       <= bit_cnt_d;
         gap_cnt_q       <= gap_cnt_d;
         start_pending_q <= start_pending_d;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   localparam int RUN_W = ($clog2(MAX_RUN_CYCLES + 1) < 8) ? 8
                        : $clog2(MAX_RUN_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN_CYCLES - 1);

   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic             timeout_q, timeout_d;
   logic             in_run;
   logic             run_enter;

   assign in_run    = (state_q == S_RUN_WAIT) || (state_q == S_RUN);
   assign run_enter = (state_q == S_IDLE) && (state_d == S_RUN_WAIT);
   // Last counted cycle: leaving now gives exactly MAX_RUN_CYCLES enabled cycles.
   assign run_hit   = in_run && (run_cnt_q == RUN_LAST);

   always_comb begin
      run_cnt_d = run_cnt_q;
      timeout_d = timeout_q;
      if (run_enter) begin
         run_cnt_d = '0;
         timeout_d = 1'b0;
      end else if (in_run) begin
         run_cnt_d = run_cnt_q + RUN_ONE;
         if (run_hit && !run_done_out) begin
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_out = timeout_q;
`else
   assign run_hit     = 1'b0;
   assign timeout_out = 1'b0;
`endif

   assign wr_ready_out = ~full;
   assign busy_out     = (state_q != S_IDLE) | ~empty | start_pending_q;
   assign csi_n_out    = ~((state_q == S_SETUP) || (state_q == S_SHIFT));
   assign csd_n_out    = 1'b1;
   assign mosi_out     = ~csi_n_out & sr_q[0];
   assign run_done_out = (state_q == S_RUN) & proc_done_in;
   // Enable drops in the very cycle done returns so EXEC is not re-entered.
   assign proc_en_out  = (state_q == S_RUN_WAIT)
                       | ((state_q == S_RUN) & ~proc_done_in);

endmodule

// File: doc/spi_program_loader.md
Name: spi_program_loader

Overview:
- Host-side master that feeds the tiny processor's serial load and run interface.
- Accepts {address, instruction} words from an upstream host over valid/ready and buffers them in a small FIFO.
- Serialises each word onto csi_n/mosi in the framing the processor's 12-bit receive buffer expects, then runs the loaded program on request by driving proc_en and watching proc_done.
- Shares clk with the processor; one mosi bit per clk.

Parameters:
- FIFO_DEPTH, 4, number of buffered 12-bit words; power of 2, ≥2.
- GAP_CYCLES, 2, csi_n-high cycles after each frame; minimum legal value 2 (processor needs RECV→WRITE→IDLE).
- MAX_RUN_CYCLES, 255, run timeout limit; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_valid_in  in  1  host word valid
- wr_ready_out  out  1  FIFO can accept (= ~full)
- wr_addr_in  in  4  instruction memory address
- wr_data_in  in  8  instruction byte
- start_in  in  1  request program run (pulse or level)
- busy_out  out  1  state != IDLE, or FIFO non-empty, or start pending
- run_done_out  out  1  one-cycle pulse when a run completes normally
- timeout_out  out  1  sticky run-timeout flag (0 when feature is off)
- csi_n_out  out  1  instruction chip select, active low
- csd_n_out  out  1  data chip select; tied 1
- mosi_out  out  1  serial data to processor
- proc_en_out  out  1  processor run enable
- proc_done_in  in  1  processor idle/done

Behaviour:
- Reset values:
  - FIFO empty, start_pending=0, state IDLE, counters 0.
  - csi_n_out=1, csd_n_out=1, mosi_out=0, proc_en_out=0.
  - run_done_out=0, timeout_out=0, wr_ready_out=1.
- Reset mid-frame or mid-run returns to these values on the next edge; the partial frame is discarded.
- FIFO:
  - Push when wr_valid_in & wr_ready_out; entry word={data,addr}, 12 bits.
  - Simultaneous push and pop is allowed when not full.
  - When full, ready=0 and no push occurs.
  - Pop happens on the SETUP entry.
- start_in:
  - Sets start_pending on any cycle it is high, including while busy.
  - start_pending clears on entry to RUN_WAIT.
- States:
  - IDLE:
    - If FIFO non-empty → SETUP; pop the word into shift register sr.
    - Else if start_pending → RUN_WAIT.
    - Loading has priority over running.
  - SETUP, 1 cycle: csi_n=0, mosi=sr[0]. Gives the processor its IDLE→RECV cycle; no bit is captured here. → SHIFT with bit counter=0.
  - SHIFT, 12 cycles: csi_n=0, mosi=sr[k] for k=0..11 (LSB first). The processor captures on the edge ending each cycle. After k=11 → GAP.
  - GAP, GAP_CYCLES cycles: csi_n=1, mosi=0. → IDLE.
  - RUN_WAIT:
    - proc_en_out=1.
    - When proc_done_in=0 (processor has entered EXEC) → RUN.
  - RUN:
    - proc_en_out = ~proc_done_in, combinational, so enable drops in the same cycle done rises and the processor cannot re-enter EXEC.
    - When proc_done_in=1 → IDLE with run_done_out=1 for exactly that transition cycle.
- csi_n framing: the frame is exactly 13 contiguous low cycles, followed by ≥GAP_CYCLES high.
- csi_n stays 1 during RUN_WAIT and RUN, and proc_en stays 0 while csi_n is low.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter clears on RUN_WAIT entry and increments each cycle in RUN_WAIT or RUN.
  - When the count reaches MAX_RUN_CYCLES: proc_en_out forced 0, timeout_out set, → IDLE, no run_done pulse.
  - timeout_out clears on rst or on the next RUN_WAIT entry.
- When undefined: no counter; timeout_out tied 0; a non-terminating program keeps RUN indefinitely.

Test Plan:
- Reset: assert rst 2 cycles → csi_n=1, csd_n=1, mosi=0, proc_en=0, wr_ready=1, busy=0, run_done=0.
- Single frame: push addr=3, data=0xA5 (word 0xA53) → 1 idle cycle, then csi_n low 13 cycles. SHIFT mosi sequence is 1,1,0,0,1,0,1,0,0,1,0,1, then csi_n high ≥2 cycles. The processor model's icache[3] reads 0xA5.
- Backpressure: push 5 words back-to-back while the first frame is in flight → wr_ready drops after FIFO holds 4; the 5th is accepted on reappearance; all 5 frames are emitted in order.
- Start pending behind load: push 2 words and pulse start the same cycle → both frames complete before proc_en rises; start_pending is cleared.
- Run handshake: model done=0 for 20 cycles after proc_en → proc_en falls combinationally in the cycle done returns to 1. run_done pulses once. The processor does not re-enter EXEC.
- Timeout (LOADER_TIMEOUT_EN, MAX_RUN_CYCLES=16): done held 0 → proc_en=0 and timeout_out=1 after 16 run cycles; run_done stays 0. Then rst mid-SHIFT → csi_n=1 on the next edge.
